// File: rtl/loop_index_sequencer.sv
// Two-level (outer x inner) loop index generator with a valid/ready output.
// Each job walks inner 0..imax for every outer 0..omax and then pulses done
// for one cycle. Abort returns to idle with cleared indices and no done pulse.
module loop_index_sequencer #(
   parameter int COUNT_WIDTH = 8
) (
   input  logic                   clk_i,
   input  logic                   rst_ni,
   input  logic                   start_i,
   input  logic                   abort_i,
   input  logic [COUNT_WIDTH-1:0] inner_max_i,
   input  logic [COUNT_WIDTH-1:0] outer_max_i,
   output logic                   idx_valid_o,
   input  logic                   idx_ready_i,
   output logic [COUNT_WIDTH-1:0] inner_idx_o,
   output logic [COUNT_WIDTH-1:0] outer_idx_o,
   output logic                   inner_last_o,
   output logic                   last_o,
   output logic                   busy_o,
   output logic                   done_o
);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_FINISH} state_e;

   state_e                 state_q, state_d;
   logic [COUNT_WIDTH-1:0] imax_q, imax_d;
   logic [COUNT_WIDTH-1:0] omax_q, omax_d;
   logic [COUNT_WIDTH-1:0] inner_q, inner_d;
   logic [COUNT_WIDTH-1:0] outer_q, outer_d;

   logic at_ilast, at_last, hs;

   // Compare against the latched bounds, never the live inputs.
   assign at_ilast = (inner_q == imax_q);
   assign at_last  = at_ilast && (outer_q == omax_q);
   assign hs       = (state_q == S_RUN) && idx_ready_i;

   // State, latched bounds and index registers.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= S_IDLE;
         imax_q  <= '0;
         omax_q  <= '0;
         inner_q <= '0;
         outer_q <= '0;
      end else begin
         state_q <= state_d;
         imax_q  <= imax_d;
         omax_q  <= omax_d;
         inner_q <= inner_d;
         outer_q <= outer_d;
      end
   end

   // Next-state and index stepping; abort outranks start and handshake.
   always_comb begin
      state_d = state_q;
      imax_d  = imax_q;
      omax_d  = omax_q;
      inner_d = inner_q;
      outer_d = outer_q;
      if (abort_i && (state_q != S_IDLE)) begin
         state_d = S_IDLE;
         inner_d = '0;
         outer_d = '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (start_i) begin
                  imax_d  = inner_max_i;
                  omax_d  = outer_max_i;
                  inner_d = '0;
                  outer_d = '0;
                  state_d = S_RUN;
               end
            end
            S_RUN: begin
               if (hs) begin
                  // The final pair leaves indices parked at (imax, omax),
                  // so nothing ever steps past its bound.
                  if (at_last) begin
                     state_d = S_FINISH;
                  end else if (!at_ilast) begin
                     inner_d = inner_q + COUNT_WIDTH'(1);
                  end else begin
                     inner_d = '0;
                     outer_d = outer_q + COUNT_WIDTH'(1);
                  end
               end
            end
            S_FINISH: state_d = S_IDLE;
            default:  state_d = S_IDLE;
         endcase
      end
   end

   assign idx_valid_o  = (state_q == S_RUN);
   assign inner_idx_o  = inner_q;
   assign outer_idx_o  = outer_q;
   assign inner_last_o = idx_valid_o && at_ilast;
   assign last_o       = idx_valid_o && at_last;
   assign busy_o       = (state_q != S_IDLE);
   assign done_o       = (state_q == S_FINISH);

endmodule

// File: tb/tb_loop_index_sequencer.sv
// Scoreboard bench: expected index pairs are queued when a job is launched
// and popped on every observed handshake. Sampling happens on the falling edge.
module tb_loop_index_sequencer;
   localparam int W = 8;
   typedef logic [2*W+1:0] ent_t;   // {outer, inner, inner_last, last}

   logic         clk = 1'b0, rst_n = 1'b0, start = 1'b0, abort = 1'b0, ready = 1'b0;
   logic [W-1:0] imax_in = '0, omax_in = '0;
   logic         idx_valid, inner_last, last, busy, done;
   logic [W-1:0] inner_idx, outer_idx;

   ent_t exp_q[$];
   int   total = 0, bad = 0;

   always #5 clk = ~clk;

   loop_index_sequencer #(.COUNT_WIDTH(W)) dut (
      .clk_i(clk), .rst_ni(rst_n), .start_i(start), .abort_i(abort),
      .inner_max_i(imax_in), .outer_max_i(omax_in),
      .idx_valid_o(idx_valid), .idx_ready_i(ready),
      .inner_idx_o(inner_idx), .outer_idx_o(outer_idx),
      .inner_last_o(inner_last), .last_o(last), .busy_o(busy), .done_o(done)
   );

   function automatic ent_t obs();
      return {outer_idx, inner_idx, inner_last, last};
   endfunction

   // Reference model: full pair stream for a job.
   function automatic void push_job(int im, int om);
      for (int o = 0; o <= om; o++)
         for (int i = 0; i <= im; i++)
            exp_q.push_back({W'(o), W'(i), (i == im), (i == im) && (o == om)});
   endfunction

   // Returns on the falling edge where the first pair is visible.
   task automatic start_job(input logic [W-1:0] im, input logic [W-1:0] om);
      @(negedge clk);
      imax_in = im; omax_in = om; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      @(negedge clk);
      total++;
      if ({idx_valid, busy, done, inner_last, last, inner_idx, outer_idx} !== '0) begin
         bad++; $display("FAIL reset_outputs got=%h exp=0",
                         {idx_valid, busy, done, inner_last, last, inner_idx, outer_idx});
      end
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_basic;
      ent_t e; int cyc = 0;
      push_job(2, 1); ready = 1'b1;
      start_job(2, 1);
      while (exp_q.size() > 0 && cyc < 50) begin
         total++;
         if (!idx_valid) begin
            bad++; $display("FAIL basic_valid got=0 exp=1 cyc=%0d", cyc);
         end else begin
            e = exp_q.pop_front();
            if (obs() !== e) begin bad++; $display("FAIL basic_pair got=%h exp=%h", obs(), e); end
         end
         @(negedge clk); cyc++;
      end
      total++;
      if (exp_q.size() != 0) begin bad++; $display("FAIL basic_timeout left=%0d exp=0", exp_q.size()); end
      total++;
      if ({done, idx_valid, busy, outer_idx, inner_idx} !== {3'b101, W'(1), W'(2)}) begin
         bad++; $display("FAIL basic_finish got=%h exp=%h",
                         {done, idx_valid, busy, outer_idx, inner_idx}, {3'b101, W'(1), W'(2)});
      end
      @(negedge clk);
      total++;
      if ({done, idx_valid, busy, outer_idx, inner_idx} !== {3'b000, W'(1), W'(2)}) begin
         bad++; $display("FAIL basic_idle got=%h exp=%h",
                         {done, idx_valid, busy, outer_idx, inner_idx}, {3'b000, W'(1), W'(2)});
      end
      exp_q.delete();
   endtask

   task automatic test_single;
      ent_t e;
      push_job(0, 0); ready = 1'b1;
      start_job(0, 0);
      e = exp_q.pop_front();
      total++;
      if ({obs(), idx_valid, busy} !== {e, 2'b11}) begin
         bad++; $display("FAIL single_pair got=%h exp=%h", {obs(), idx_valid, busy}, {e, 2'b11});
      end
      @(negedge clk);
      total++;
      if ({done, busy, idx_valid} !== 3'b110) begin
         bad++; $display("FAIL single_done got=%b exp=110", {done, busy, idx_valid});
      end
      @(negedge clk);
      total++;
      if ({done, busy, idx_valid} !== 3'b000) begin
         bad++; $display("FAIL single_idle got=%b exp=000", {done, busy, idx_valid});
      end
   endtask

   task automatic test_ready_toggle;
      ent_t e, prev; logic r = 1'b1, have_prev = 1'b0; int cyc = 0;
      push_job(2, 1);
      ready = 1'b1;
      start_job(2, 1);
      while (exp_q.size() > 0 && cyc < 60) begin
         ready = r;
         if (have_prev) begin
            total++;
            if ({obs(), idx_valid} !== {prev, 1'b1}) begin
               bad++; $display("FAIL toggle_stable got=%h exp=%h", {obs(), idx_valid}, {prev, 1'b1});
            end
         end
         if (done) begin total++; bad++; $display("FAIL toggle_early_done got=1 exp=0"); end
         if (idx_valid && ready) begin
            e = exp_q.pop_front(); have_prev = 1'b0;
            total++;
            if (obs() !== e) begin bad++; $display("FAIL toggle_pair got=%h exp=%h", obs(), e); end
         end else begin
            have_prev = 1'b1; prev = obs();
         end
         r = ~r;
         @(negedge clk); cyc++;
      end
      total++;
      if (exp_q.size() != 0) begin bad++; $display("FAIL toggle_timeout left=%0d exp=0", exp_q.size()); end
      total++;
      if ({done, idx_valid} !== 2'b10) begin
         bad++; $display("FAIL toggle_done got=%b exp=10", {done, idx_valid});
      end
      @(negedge clk);
      exp_q.delete();
   endtask

   task automatic test_abort;
      ent_t e;
      push_job(2, 1); ready = 1'b1;
      start_job(2, 1);
      for (int k = 0; k < 3; k++) begin
         e = exp_q.pop_front();
         total++;
         if ({obs(), idx_valid} !== {e, 1'b1}) begin
            bad++; $display("FAIL abort_pre got=%h exp=%h", {obs(), idx_valid}, {e, 1'b1});
         end
         @(negedge clk);
      end
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      total++;
      if ({idx_valid, busy, done, inner_idx, outer_idx} !== '0) begin
         bad++; $display("FAIL abort_clear got=%h exp=0", {idx_valid, busy, done, inner_idx, outer_idx});
      end
      @(negedge clk);
      total++;
      if ({done, busy} !== 2'b00) begin bad++; $display("FAIL abort_nodone got=%b exp=00", {done, busy}); end
      exp_q.delete();
      push_job(2, 1);
      start_job(2, 1);
      e = exp_q.pop_front();
      total++;
      if ({obs(), idx_valid} !== {e, 1'b1}) begin
         bad++; $display("FAIL abort_restart got=%h exp=%h", {obs(), idx_valid}, {e, 1'b1});
      end
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      exp_q.delete();
      @(negedge clk);
   endtask

   task automatic test_start_ignored;
      ent_t e; int cyc = 0;
      push_job(2, 1); ready = 1'b1;
      start_job(2, 1);
      while (exp_q.size() > 0 && cyc < 50) begin
         if (cyc == 2) begin start = 1'b1; imax_in = 8'd5; omax_in = 8'd5; end
         if (cyc == 3) start = 1'b0;
         total++;
         if (!idx_valid) begin
            bad++; $display("FAIL ign_valid got=0 exp=1 cyc=%0d", cyc);
         end else begin
            e = exp_q.pop_front();
            if (obs() !== e) begin bad++; $display("FAIL ign_pair got=%h exp=%h", obs(), e); end
         end
         @(negedge clk); cyc++;
      end
      total++;
      if ({done, exp_q.size() == 0} !== 2'b11) begin
         bad++; $display("FAIL ign_done got=%b left=%0d exp=1", done, exp_q.size());
      end
      @(negedge clk);
      total++;
      if ({busy, idx_valid} !== 2'b00) begin bad++; $display("FAIL ign_idle got=%b exp=00", {busy, idx_valid}); end
      exp_q.delete();
   endtask

   task automatic test_back_to_back;
      ent_t e; int cyc = 0;
      push_job(1, 0); ready = 1'b1;
      start_job(1, 0);
      while (exp_q.size() > 0 && cyc < 20) begin
         e = exp_q.pop_front();
         total++;
         if ({obs(), idx_valid} !== {e, 1'b1}) begin
            bad++; $display("FAIL b2b_pair got=%h exp=%h", {obs(), idx_valid}, {e, 1'b1});
         end
         @(negedge clk); cyc++;
      end
      // FINISH cycle: a start here must be dropped.
      imax_in = '0; omax_in = '0; start = 1'b1;
      total++;
      if (done !== 1'b1) begin bad++; $display("FAIL b2b_done got=%b exp=1", done); end
      @(negedge clk);
      total++;
      if ({busy, idx_valid} !== 2'b00) begin bad++; $display("FAIL b2b_finish_start got=%b exp=00", {busy, idx_valid}); end
      @(negedge clk);
      start = 1'b0;
      push_job(0, 0);
      e = exp_q.pop_front();
      total++;
      if ({obs(), idx_valid, busy} !== {e, 2'b11}) begin
         bad++; $display("FAIL b2b_restart got=%h exp=%h", {obs(), idx_valid, busy}, {e, 2'b11});
      end
      @(negedge clk);
      @(negedge clk);
   endtask

   task automatic test_reset_mid;
      ready = 1'b1;
      start_job(2, 1);
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      total++;
      if ({idx_valid, busy, done, inner_last, last, inner_idx, outer_idx} !== '0) begin
         bad++; $display("FAIL rst_async got=%h exp=0",
                         {idx_valid, busy, done, inner_last, last, inner_idx, outer_idx});
      end
      #1 rst_n = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         total++;
         if ({idx_valid, busy, done} !== 3'b000) begin
            bad++; $display("FAIL rst_idle got=%b exp=000 k=%0d", {idx_valid, busy, done}, k);
         end
      end
   endtask

   initial begin
      test_reset;
      test_basic;
      test_single;
      test_ready_toggle;
      test_abort;
      test_start_ignored;
      test_back_to_back;
      test_reset_mid;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
